// File: rtl/host_frame_assembler_if.sv
// ---------------------------------------------------------------------------
// host_frame_assembler_if
// Bundles the byte stream from the UART receiver, the clearDR handshake from
// the sandbox process and the assembled-word outputs into one interface.
//   master : drives rxByteValid/rxByte/clearDR, observes the word outputs
//   slave  : the assembler side (consumes bytes, presents the word)
// Signals:
//   rxByteValid  one-cycle strobe, rxByte holds a new received byte
//   rxByte       received byte
//   clearDR      the process has consumed the current word
//   dataReceived control/inputData hold a complete, valid frame
//   control      assembled control byte
//   inputData    assembled data word, first data byte in bits [7:0]
//   frameError   one-cycle pulse on timeout or checksum failure
//   rxOverrun    one-cycle pulse when a byte is dropped while a word is held
// ---------------------------------------------------------------------------
interface host_frame_assembler_if;
  logic        rxByteValid;
  logic [7:0]  rxByte;
  logic        clearDR;
  logic        dataReceived;
  logic [7:0]  control;
  logic [31:0] inputData;
  logic        frameError;
  logic        rxOverrun;

  modport master (
    output rxByteValid, rxByte, clearDR,
    input  dataReceived, control, inputData, frameError, rxOverrun
  );

  modport slave (
    input  rxByteValid, rxByte, clearDR,
    output dataReceived, control, inputData, frameError, rxOverrun
  );
endinterface

// File: rtl/host_frame_assembler.sv
// ---------------------------------------------------------------------------
// host_frame_assembler
// Assembles framed host commands from the UART byte stream:
//   SYNC, CTRL, D0, D1, D2, D3 [, CHK]
// into an 8-bit control byte and a 32-bit data word (D0 in bits [7:0]).
// The word is flagged with dataReceived and held until the sandbox process
// answers with clearDR; a new frame is only hunted for once clearDR drops.
//
// Optional feature: define FRAME_CHECKSUM_EN to require a trailing byte equal
// to CTRL^D0^D1^D2^D3. Without it, D3 commits the frame directly.
//
// Ports:
//   masterClock  operating clock
//   reset        synchronous, active-low reset
//   hbus         host_frame_assembler_if.slave (byte stream in, word out)
// ---------------------------------------------------------------------------
module host_frame_assembler #(
  parameter logic [7:0]  FRAME_SYNC     = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_W           = 20
) (
  input  logic                 masterClock,
  input  logic                 reset,
  host_frame_assembler_if.slave hbus
);

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_CTRL    = 3'd1,
    ST_DATA    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
`ifdef FRAME_CHECKSUM_EN
    , ST_CHK   = 3'd5
`endif
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef FRAME_CHECKSUM_EN
  // XOR over the control byte and the four data bytes of a frame.
  function automatic logic [7:0] frame_checksum(input logic [7:0]  ctrl,
                                                input logic [31:0] data);
    frame_checksum = ctrl ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24];
  endfunction
`endif

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]       ctrl_sh_q, ctrl_sh_d;
  logic [31:0]      data_sh_q, data_sh_d;
  logic [7:0]       control_q, control_d;
  logic [31:0]      input_data_q, input_data_d;
  logic             data_received_q, data_received_d;
  logic             frame_error_q, frame_error_d;
  logic             rx_overrun_q, rx_overrun_d;

  // Inter-byte timer expiry: only meaningful while inside a frame.
  logic             to_expire_s;
  assign to_expire_s = (to_cnt_q == TO_LAST);

  // Next-state and output computation for the frame FSM.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    to_cnt_d      = to_cnt_q;
    ctrl_sh_d     = ctrl_sh_q;
    data_sh_d     = data_sh_q;
    control_d     = control_q;
    input_data_d  = input_data_q;
    frame_error_d = 1'b0;
    rx_overrun_d  = 1'b0;

    case (state_q)
      ST_HUNT: begin
        to_cnt_d = '0;
        if (hbus.rxByteValid && (hbus.rxByte == FRAME_SYNC)) begin
          state_d = ST_CTRL;
        end else begin
          state_d = ST_HUNT;
        end
      end

      ST_CTRL: begin
        // A byte in the same cycle as expiry wins over the timeout.
        if (hbus.rxByteValid) begin
          ctrl_sh_d  = hbus.rxByte;
          byte_cnt_d = 2'd0;
          to_cnt_d   = '0;
          state_d    = ST_DATA;
        end else if (to_expire_s) begin
          frame_error_d = 1'b1;
          to_cnt_d      = '0;
          ctrl_sh_d     = 8'h00;
          data_sh_d     = 32'h0000_0000;
          state_d       = ST_HUNT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_DATA: begin
        if (hbus.rxByteValid) begin
          data_sh_d[{byte_cnt_q, 3'b000} +: 8] = hbus.rxByte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          to_cnt_d   = '0;
          if (byte_cnt_q == 2'd3) begin
`ifdef FRAME_CHECKSUM_EN
            state_d = ST_CHK;
`else
            control_d    = ctrl_sh_q;
            input_data_d = data_sh_d;
            state_d      = ST_HOLD;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else if (to_expire_s) begin
          frame_error_d = 1'b1;
          to_cnt_d      = '0;
          ctrl_sh_d     = 8'h00;
          data_sh_d     = 32'h0000_0000;
          state_d       = ST_HUNT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

`ifdef FRAME_CHECKSUM_EN
      ST_CHK: begin
        if (hbus.rxByteValid) begin
          to_cnt_d = '0;
          if (hbus.rxByte == frame_checksum(ctrl_sh_q, data_sh_q)) begin
            control_d    = ctrl_sh_q;
            input_data_d = data_sh_q;
            state_d      = ST_HOLD;
          end else begin
            frame_error_d = 1'b1;
            ctrl_sh_d     = 8'h00;
            data_sh_d     = 32'h0000_0000;
            state_d       = ST_HUNT;
          end
        end else if (to_expire_s) begin
          frame_error_d = 1'b1;
          to_cnt_d      = '0;
          ctrl_sh_d     = 8'h00;
          data_sh_d     = 32'h0000_0000;
          state_d       = ST_HUNT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
`endif

      ST_HOLD: begin
        // The held word is never overwritten; extra bytes are dropped.
        rx_overrun_d = hbus.rxByteValid;
        if (hbus.clearDR) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_RELEASE: begin
        // Hunting resumes only after clearDR drops, so a new word can never
        // be flagged while the process still asserts clearDR.
        rx_overrun_d = hbus.rxByteValid;
        if (!hbus.clearDR) begin
          state_d = ST_HUNT;
        end else begin
          state_d = ST_RELEASE;
        end
      end

      default: begin
        state_d  = ST_HUNT;
        to_cnt_d = '0;
      end
    endcase

    data_received_d = (state_d == ST_HOLD);
  end

  // State, shadow and output registers with synchronous active-low reset.
  always_ff @(posedge masterClock) begin
    if (!reset) begin
      state_q         <= ST_HUNT;
      byte_cnt_q      <= 2'd0;
      to_cnt_q        <= '0;
      ctrl_sh_q       <= 8'h00;
      data_sh_q       <= 32'h0000_0000;
      control_q       <= 8'h00;
      input_data_q    <= 32'h0000_0000;
      data_received_q <= 1'b0;
      frame_error_q   <= 1'b0;
      rx_overrun_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      byte_cnt_q      <= byte_cnt_d;
      to_cnt_q        <= to_cnt_d;
      ctrl_sh_q       <= ctrl_sh_d;
      data_sh_q       <= data_sh_d;
      control_q       <= control_d;
      input_data_q    <= input_data_d;
      data_received_q <= data_received_d;
      frame_error_q   <= frame_error_d;
      rx_overrun_q    <= rx_overrun_d;
    end
  end

  assign hbus.dataReceived = data_received_q;
  assign hbus.control      = control_q;
  assign hbus.inputData    = input_data_q;
  assign hbus.frameError   = frame_error_q;
  assign hbus.rxOverrun    = rx_overrun_q;

endmodule
